// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and lane helper for the systolic-array output path.
package cnn_pkg;

  localparam int unsigned data_size     = 8;
  localparam int unsigned array_size    = 9;
  localparam int unsigned dim_data_size = 8;
  localparam int unsigned addr_w        = 20;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_write = 2'd1,
    st_done  = 2'd2
  } state_t;

  // Extract lane idx from a packed row of array_size words.
  function automatic logic [data_size-1:0] lane_slice(
    input logic [data_size*array_size-1:0] vec,
    input int unsigned                     idx
  );
    return vec[idx*data_size +: data_size];
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Synchronous FIFO of aligned MAC rows. The caller guarantees push only when
// not full (or when popping in the same cycle) and pop only when not empty.
module row_fifo #(
  parameter int unsigned width = 72,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned ptr_w = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   count <= count + (ptr_w+1)'(1);
        2'b01:   count <= count - (ptr_w+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Row storage; a push into a full FIFO that is popping the same cycle
  // overwrites the slot being read out, which is safe at the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (ptr_w+1)'(depth));
  assign empty = (count == '0);

endmodule

// File: rtl/ofmap_writer.sv
// Deskews systolic MAC output rows, buffers them, and streams the words of an
// output feature map to memory starting at initial_address.
module ofmap_writer #(
  parameter int unsigned data_size     = cnn_pkg::data_size,
  parameter int unsigned array_size    = cnn_pkg::array_size,
  parameter int unsigned dim_data_size = cnn_pkg::dim_data_size,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                            s_clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [cnn_pkg::addr_w-1:0]      initial_address,
  input  logic [dim_data_size-1:0]        Weight_size,
  input  logic [dim_data_size-1:0]        image_height,
  input  logic [dim_data_size-1:0]        image_width,
  input  logic                            mac_valid,
  input  logic [data_size*array_size-1:0] macout,
  output logic                            mac_ready,
  output logic [cnn_pkg::addr_w-1:0]      mem_addr,
  output logic [data_size-1:0]            mem_wdata,
  output logic                            mem_we,
  input  logic                            mem_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err,
  output logic                            overflow
);

  import cnn_pkg::*;

  localparam int unsigned row_w  = data_size * array_size;
  localparam int unsigned cnt_w  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned lane_w = $clog2(array_size);
  localparam int unsigned inf_w  = $clog2(array_size);
  localparam int unsigned tot_w  = 2 * dim_data_size;

  state_t state, state_nxt;

  logic [addr_w-1:0]        addr;
  logic [tot_w-1:0]         total;
  logic [tot_w-1:0]         written;
  logic [lane_w-1:0]        lane_idx;
  logic                     cfg_done_q;

  logic [array_size-2:0]    v_dly;
  logic [inf_w-1:0]         inflight;
  logic [row_w-1:0]         aligned_row;
  logic                     row_valid;

  logic [row_w-1:0]         head_row;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [cnt_w-1:0]         fifo_count;
  logic                     fifo_push;
  logic                     fifo_pop;

  logic                     cfg_bad;
  logic                     start_ok;
  logic [dim_data_size-1:0] rows_out;
  logic [dim_data_size-1:0] cols_out;
  logic [tot_w-1:0]         total_calc;
  logic                     presenting;
  logic                     xfer;
  logic                     last_word;
  logic                     lane_end;
  logic                     row_live;
  logic                     drop_row;

  // ---------------------------------------------------------------- deskew
  // Lane i waits array_size-1-i cycles so all lanes of a beat line up with
  // the last lane, which is used straight from macout.
  for (genvar i = 0; i < array_size - 1; i++) begin : g_lane
    localparam int unsigned depth_l = array_size - 1 - i;
    logic [data_size-1:0] dly [depth_l];

    // Per-lane delay line.
    always_ff @(posedge s_clk) begin
      if (reset) begin
        for (int unsigned j = 0; j < depth_l; j++) dly[j] <= '0;
      end else begin
        dly[0] <= lane_slice(macout, i);
        for (int unsigned j = 1; j < depth_l; j++) dly[j] <= dly[j-1];
      end
    end

    assign aligned_row[i*data_size +: data_size] = dly[depth_l-1];
  end

  assign aligned_row[(array_size-1)*data_size +: data_size] = lane_slice(macout, array_size - 1);

  // Valid delay line, aligned with the deskewed row.
  always_ff @(posedge s_clk) begin
    if (reset) v_dly <= '0;
    else       v_dly <= {v_dly[array_size-3:0], mac_valid};
  end

  assign row_valid = v_dly[array_size-2];

  // Beats already accepted but not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < array_size - 1; k++) inflight = inflight + inf_w'(v_dly[k]);
  end

  assign mac_ready = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;

  // ---------------------------------------------------------------- buffer
  assign presenting = (state == st_write) && !fifo_empty;
  assign xfer       = presenting && mem_ready;
  assign last_word  = (written + tot_w'(1)) == total;
  assign lane_end   = (lane_idx == lane_w'(array_size - 1));
  assign fifo_pop   = xfer && (lane_end || last_word);
  assign row_live   = row_valid && (state != st_idle);
  // A full FIFO still takes a row when its head leaves on the same edge.
  assign fifo_push  = row_live && (!fifo_full || fifo_pop);
  assign drop_row   = row_live && fifo_full && !fifo_pop;

  row_fifo #(
    .width (row_w),
    .depth (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (s_clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (aligned_row),
    .dout  (head_row),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------- config
  assign cfg_bad    = (Weight_size == '0) || (Weight_size > image_height) || (Weight_size > image_width);
  assign start_ok   = start && (state == st_idle);
  assign rows_out   = image_height - Weight_size + dim_data_size'(1);
  assign cols_out   = image_width  - Weight_size + dim_data_size'(1);
  assign total_calc = tot_w'(rows_out) * tot_w'(cols_out);

  // ---------------------------------------------------------------- FSM
  // State register.
  always_ff @(posedge s_clk) begin
    if (reset) state <= st_idle;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:  if (start && !cfg_bad) state_nxt = st_write;
      st_write: if (xfer && last_word) state_nxt = st_done;
      st_done:  state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
  end

  // Output decode.
  always_comb begin
    busy      = (state != st_idle);
    done      = (state == st_done) || cfg_done_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (presenting) begin
      mem_we    = 1'b1;
      mem_addr  = addr;
      mem_wdata = lane_slice(head_row, 32'(lane_idx));
    end
  end

  // Frame datapath: config latch, address/word/lane counters, sticky flags.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      addr       <= '0;
      total      <= '0;
      written    <= '0;
      lane_idx   <= '0;
      cfg_done_q <= 1'b0;
      cfg_err    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cfg_done_q <= start_ok && cfg_bad;
      if (start_ok) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          addr     <= initial_address;
          total    <= total_calc;
          written  <= '0;
          lane_idx <= '0;
        end
      end else if (xfer) begin
        addr     <= addr + addr_w'(1);
        written  <= written + tot_w'(1);
        lane_idx <= (lane_end || last_word) ? '0 : lane_idx + lane_w'(1);
      end
      if (drop_row) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
// Scoreboard bench for ofmap_writer: expected writes are queued as stimulus
// is issued and retired by a write monitor.
module tb_ofmap_writer;

  logic        s_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] initial_address = '0;
  logic [7:0]  Weight_size = 8'd3;
  logic [7:0]  image_height = 8'd5;
  logic [7:0]  image_width = 8'd5;
  logic        mac_valid = 1'b0;
  logic [71:0] macout = '0;
  logic        mac_ready;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        busy, done, cfg_err, overflow;

  always #5 s_clk = ~s_clk;

  ofmap_writer #(
    .data_size     (8),
    .array_size    (9),
    .dim_data_size (8),
    .FIFO_DEPTH    (4)
  ) dut (
    .s_clk           (s_clk),
    .reset           (reset),
    .start           (start),
    .initial_address (initial_address),
    .Weight_size     (Weight_size),
    .image_height    (image_height),
    .image_width     (image_width),
    .mac_valid       (mac_valid),
    .macout          (macout),
    .mac_ready       (mac_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_ready       (mem_ready),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .overflow        (overflow)
  );

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_writes, first_we_cyc, last_wr_cyc, done_cnt, done_cyc;
  logic [7:0] bdat [8][9];
  logic rdy_seen [8];

  always @(posedge s_clk) cyc <= cyc + 1;

  // Write monitor: retires expected writes and records event timing.
  always @(negedge s_clk) begin : mon
    wr_t e;
    if (mem_we === 1'b1 && first_we_cyc < 0) first_we_cyc = cyc;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_we === 1'b1 && mem_ready === 1'b1) begin
      n_writes++;
      last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic clear_mon();
    n_writes = 0;
    first_we_cyc = -1;
    last_wr_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic do_start(input logic [19:0] base, input logic [7:0] h, input logic [7:0] w,
                          input logic [7:0] k);
    initial_address = base;
    image_height = h;
    image_width = w;
    Weight_size = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_expect(input logic [19:0] base, input int total);
    for (int k = 0; k < total; k++) begin
      wr_t e;
      e.addr = base + 20'(k);
      e.data = bdat[k/9][k%9];
      exp_q.push_back(e);
    end
  endtask

  // Issue n back-to-back beats with lane i skewed by i cycles; t is the
  // cycle in which mac_valid of the first beat is high.
  task automatic drive_beats(input int n, output int t);
    t = cyc;
    for (int c = 0; c < n + 8; c++) begin
      if (c < n) rdy_seen[c] = mac_ready;
      mac_valid = (c < n);
      for (int i = 0; i < 9; i++) begin
        int b;
        b = c - i;
        macout[i*8 +: 8] = (b >= 0 && b < n) ? bdat[b][i] : 8'h00;
      end
      step();
    end
    mac_valid = 1'b0;
    macout = '0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done_cnt > 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if ({mac_ready, mem_we, busy, done, cfg_err, overflow} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 100000",
               {mac_ready, mem_we, busy, done, cfg_err, overflow});
    end
    checks++;
    if (mem_addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h, required 00000", mem_addr);
    end
    checks++;
    if (mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_wdata: got %h, required 00", mem_wdata);
    end
  endtask

  task automatic test_nominal();
    int t;
    for (int i = 0; i < 9; i++) bdat[0][i] = 8'(i + 1);
    clear_mon();
    do_start(20'h00000, 8'd5, 8'd5, 8'd3);
    push_expect(20'h00000, 9);
    drive_beats(1, t);
    wait_done(60);
    step();
    step();
    checks++;
    if (n_writes != 9 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL nominal_count: got %0d writes (%0d pending), required 9 (0)", n_writes, exp_q.size());
    end
    // mac_valid cycle counts as cycle 1, so the first write lands in cycle 10.
    checks++;
    if (first_we_cyc != t + 9) begin
      errors++;
      $display("FAIL nominal_latency: got %0d, required %0d", first_we_cyc - t, 9);
    end
    checks++;
    if (last_wr_cyc != t + 17) begin
      errors++;
      $display("FAIL nominal_last_write: got %0d, required %0d", last_wr_cyc - t, 17);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != t + 18) begin
      errors++;
      $display("FAIL nominal_done: got %0d pulses at %0d, required 1 at %0d", done_cnt, done_cyc - t, 18);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_partial_wrap();
    int t;
    for (int i = 0; i < 9; i++) begin
      bdat[0][i] = 8'(8'h10 + i);
      bdat[1][i] = 8'(8'h20 + i);
    end
    clear_mon();
    do_start(20'hFFFFE, 8'd6, 8'd6, 8'd3);
    push_expect(20'hFFFFE, 16);
    drive_beats(2, t);
    wait_done(80);
    step();
    step();
    checks++;
    if (n_writes != 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL partial_count: got %0d writes (%0d pending), required 16 (0)", n_writes, exp_q.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc != t + 25) begin
      errors++;
      $display("FAIL partial_done: got %0d pulses at %0d, required 1 at %0d", done_cnt, done_cyc - t, 25);
    end
    checks++;
    if (mac_ready !== 1'b1) begin
      errors++;
      $display("FAIL partial_drained: got mac_ready=%b, required 1", mac_ready);
    end
  endtask

  task automatic test_backpressure();
    int   t, exp_done, cnt, hold_n;
    logic prev_stall;
    logic [19:0] paddr;
    logic [7:0]  pdata;
    for (int i = 0; i < 9; i++) bdat[0][i] = 8'(8'hA0 + i);
    clear_mon();
    do_start(20'h00040, 8'd5, 8'd5, 8'd3);
    mem_ready = 1'b0;
    push_expect(20'h00040, 9);
    drive_beats(1, t);
    // Ready pattern 1,0,0 repeating from the beat cycle; data is available
    // from t+9, so each ready cycle from then on retires one word.
    cnt = 0;
    exp_done = -1;
    for (int c = t + 9; cnt < 9; c++) begin
      if ((c - t) % 3 == 0) begin
        cnt++;
        if (cnt == 9) exp_done = c + 1;
      end
    end
    prev_stall = 1'b0;
    paddr = '0;
    pdata = '0;
    hold_n = 0;
    for (int k = 0; k < 120; k++) begin
      if (prev_stall) begin
        hold_n++;
        checks++;
        if (mem_addr !== paddr || mem_wdata !== pdata) begin
          errors++;
          $display("FAIL stall_hold: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, paddr, pdata);
        end
      end
      if (done_cnt > 0) break;
      mem_ready = ((cyc - t) % 3 == 0);
      prev_stall = mem_we && !mem_ready;
      paddr = mem_addr;
      pdata = mem_wdata;
      step();
    end
    mem_ready = 1'b1;
    checks++;
    if (hold_n != 16) begin
      errors++;
      $display("FAIL stall_cycles: got %0d, required 16", hold_n);
    end
    checks++;
    if (n_writes != 9 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d writes (%0d pending), required 9 (0)", n_writes, exp_q.size());
    end
    checks++;
    if (done_cyc != exp_done) begin
      errors++;
      $display("FAIL bp_done: got %0d, required %0d", done_cyc - t, exp_done - t);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int t;
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 9; i++) bdat[b][i] = 8'(8'h40 + b * 16 + i);
    clear_mon();
    do_start(20'h00200, 8'd8, 8'd8, 8'd3);
    mem_ready = 1'b0;
    push_expect(20'h00200, 36);
    drive_beats(5, t);
    checks++;
    if ({rdy_seen[0], rdy_seen[1], rdy_seen[2], rdy_seen[3], rdy_seen[4]} !== 5'b11110) begin
      errors++;
      $display("FAIL b2b_mac_ready: got %b, required 11110",
               {rdy_seen[0], rdy_seen[1], rdy_seen[2], rdy_seen[3], rdy_seen[4]});
    end
    checks++;
    if ({overflow, mac_ready, mem_we} !== 3'b101 || n_writes != 0) begin
      errors++;
      $display("FAIL b2b_overflow: got ovf/ready/we=%b writes=%0d, required 101 writes=0",
               {overflow, mac_ready, mem_we}, n_writes);
    end
    mem_ready = 1'b1;
    wait_done(100);
    step();
    checks++;
    if (n_writes != 36 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes (%0d pending), required 36 (0)", n_writes, exp_q.size());
    end
    checks++;
    if ({overflow, mac_ready, busy} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_end: got ovf/ready/busy=%b, required 110", {overflow, mac_ready, busy});
    end
  endtask

  task automatic test_bad_config();
    clear_mon();
    do_start(20'h00300, 8'd5, 8'd5, 8'd6);
    checks++;
    if ({done, cfg_err, busy, mem_we} !== 4'b1100) begin
      errors++;
      $display("FAIL badcfg_pulse: got done/err/busy/we=%b, required 1100", {done, cfg_err, busy, mem_we});
    end
    step();
    checks++;
    if ({done, cfg_err, busy} !== 3'b010) begin
      errors++;
      $display("FAIL badcfg_after: got done/err/busy=%b, required 010", {done, cfg_err, busy});
    end
    for (int k = 0; k < 12; k++) step();
    checks++;
    if (first_we_cyc != -1 || n_writes != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL badcfg_quiet: got we_cycle=%0d writes=%0d dones=%0d, required -1 0 1",
               first_we_cyc, n_writes, done_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int t;
    for (int i = 0; i < 9; i++) bdat[0][i] = 8'(8'h60 + i);
    clear_mon();
    do_start(20'h00100, 8'd5, 8'd5, 8'd3);
    push_expect(20'h00100, 9);
    drive_beats(1, t);
    for (int k = 0; k < 40; k++) begin
      if (n_writes >= 3) break;
      step();
    end
    checks++;
    if (n_writes != 3) begin
      errors++;
      $display("FAIL midreset_progress: got %0d writes, required 3", n_writes);
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    step();
    checks++;
    if ({mac_ready, mem_we, busy, done, cfg_err, overflow} !== 6'b100000 ||
        mem_addr !== 20'h0 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got flags=%b addr=%h data=%h, required 100000 00000 00",
               {mac_ready, mem_we, busy, done, cfg_err, overflow}, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    mem_ready = 1'b1;
    step();
    clear_mon();
    do_start(20'h00100, 8'd5, 8'd5, 8'd3);
    push_expect(20'h00100, 9);
    drive_beats(1, t);
    wait_done(60);
    step();
    checks++;
    if (n_writes != 9 || exp_q.size() != 0 || first_we_cyc != t + 9) begin
      errors++;
      $display("FAIL midreset_restart: got %0d writes (%0d pending) first at %0d, required 9 (0) at 9",
               n_writes, exp_q.size(), first_we_cyc - t);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_nominal();
    test_partial_wrap();
    test_backpressure();
    test_back_to_back();
    test_bad_config();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofmap_writer.md
Name: ofmap_writer

Overview:
- Output-side counterpart of the systolic-array datapath: consumes the skewed `macout` result vectors and writes them to output memory as a serial word stream.
- The input-side reader fetches image data from `initial_address` onward; this block writes output feature-map words from its own `initial_address` onward.
- Deskews per-lane results, buffers aligned rows in a small FIFO, and counts out exactly `(image_height-Weight_size+1)*(image_width-Weight_size+1)` words.
- Runs on `s_clk` only.

Parameters:
- `data_size`, 8: width of one MAC result word / memory word.
- `array_size`, 9: number of systolic lanes; `macout` carries `array_size` words.
- `dim_data_size`, 8: width of dimension inputs.
- `FIFO_DEPTH`, 4: aligned-row FIFO depth (power of 2).

Ports:
- `s_clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches config and begins a frame.
- `initial_address`  in  20  first output word address.
- `Weight_size`  in  `dim_data_size`  kernel side K.
- `image_height`  in  `dim_data_size`  H.
- `image_width`  in  `dim_data_size`  W.
- `mac_valid`  in  1  lane 0 of `macout` valid this cycle; lane i is valid i cycles later.
- `macout`  in  `data_size*array_size`  lane i at bits `[i*data_size +: data_size]`.
- `mac_ready`  out  1  upstream may issue a new beat.
- `mem_addr`  out  20  write address.
- `mem_wdata`  out  `data_size`  write data.
- `mem_we`  out  1  write request.
- `mem_ready`  in  1  memory accepts; a transfer occurs when `mem_we && mem_ready`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last write.
- `cfg_err`  out  1  sticky; bad dimensions.
- `overflow`  out  1  sticky; a row was dropped.

Behaviour:
- **Reset** (synchronous, active-high) clears all outputs to 0 except `mac_ready`, which is 1. It also empties the FIFO and deskew lines, returns the FSM to IDLE, and clears the sticky flags. Reset in mid-frame abandons the frame with no further writes.
- **Config check.** On `start` in IDLE, latch the address and dimensions.
  - If K==0, K>H or K>W: set `cfg_err`, pulse `done` the next cycle, stay IDLE.
  - Otherwise `total = (H-K+1)*(W-K+1)`, `2*dim_data_size` bits wide.
  - `start` while not IDLE is ignored.
- **Deskew.** Lane i passes through a delay line of `array_size-1-i` registers. `mac_valid` passes through `array_size-1` registers.
  - A beat whose `mac_valid` is high at cycle t appears as an aligned row at t+`array_size`-1.
  - It is pushed into the FIFO on that edge.
  - Back-to-back beats are legal every cycle.
  - Deskew runs in every state; rows arriving in IDLE are discarded.
- **Flow control.**
  - `mac_ready = (fifo_count + inflight) < FIFO_DEPTH`, where `inflight` is the number of valid bits in the delay line.
  - If an aligned row arrives while the FIFO is full (i.e. upstream ignored `mac_ready`), drop the row and set `overflow`. Nothing else changes.
- **FSM states:** IDLE, WRITE, DONE.
  - IDLE -> WRITE on a valid `start`.
  - In WRITE with the FIFO non-empty: present lane `lane_idx` of the head row. `mem_we=1`, `mem_addr=addr`, `mem_wdata=lane word`.
  - On each transfer:
    - `addr+1`, wrapping modulo 2^20;
    - `written+1`;
    - `lane_idx+1`.
  - After lane `array_size-1`, pop the head row and reset `lane_idx` to 0.
  - When `written` reaches `total`:
    - pop the head row, discarding its remaining lanes;
    - go to DONE.
  - DONE pulses `done` for one cycle, then returns to IDLE.
  - `mem_we` stays low while the FIFO is empty.
  - `mem_addr` and `mem_wdata` hold stable while `mem_we && !mem_ready`.
- **Simultaneous push and pop** in one cycle are both honoured; the count is unchanged.
- **Latency.** A row entering an empty FIFO at edge e produces `mem_we=1` in the cycle after e. With `mem_ready` tied high, the FIFO sustains 1 word per cycle.
- `busy` = state != IDLE.

Decomposition:
- Shared package `cnn_pkg` holds:
  - `data_size`, `array_size`, `dim_data_size`;
  - an address-width constant of 20;
  - the FSM state encoding `st_idle`/`st_write`/`st_done`;
  - a lane-slice helper function.
- One sub-module: `row_fifo`, a synchronous FIFO parameterised by width (`data_size*array_size`) and depth, with push, pop, full, empty and count.

Test Plan:
- Nominal 5x5 image, K=3, base 0, `array_size`=9, one beat with lanes 1..9, `mem_ready`=1:
  - writes 1..9 to addresses 0..8 on consecutive cycles;
  - then one `done` pulse;
  - first `mem_we` 10 cycles after `mac_valid`.
- Partial last row, 6x6 image, K=3 (total 16), two beats, base 0xFFFFE:
  - 16 writes, with the 2nd row's lanes 7..8 discarded;
  - address wraps 0xFFFFF -> 0x00000.
- Backpressure: `mem_ready` toggles 1,0,0,1,... during the nominal case.
  - `mem_addr`/`mem_wdata` hold while stalled;
  - the data sequence is unchanged; `done` is delayed accordingly.
- Back-to-back beats with `mem_ready`=0:
  - `mac_ready` drops after 4 beats in flight or buffered;
  - forcing a 5th beat sets `overflow`, and the first 4 rows write intact.
- Bad config K=6, H=W=5:
  - `cfg_err`=1, `done` pulse one cycle after `start`, no `mem_we`.
- Reset asserted mid-WRITE after 3 words:
  - next cycle all outputs are at reset values;
  - a new `start` rewrites from `initial_address` correctly.
